// File: rtl/fetch_sram_responder.sv
// Two-stage instruction-fetch responder in front of a synchronous-read SRAM.
// The address phase is accepted combinationally; the data phase returns one word, in order, after optional wait states.
module fetch_sram_responder #(
  parameter int                W_ADDR      = 32,
  parameter int                W_DATA      = 32,
  parameter logic [W_ADDR-1:0] BASE_ADDR   = '0,
  parameter int                DEPTH_WORDS = 4096,
  parameter int                WAIT_STATES = 0,
  localparam int               AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_size,
  input  logic [W_ADDR-1:0] mem_addr,
  input  logic              mem_addr_vld,
  output logic              mem_addr_rdy,
  output logic [W_DATA-1:0] mem_data,
  output logic              mem_data_vld,
  input  logic              stall_in,
  output logic              sram_ren,
  output logic [AW-1:0]     sram_addr,
  input  logic [W_DATA-1:0] sram_rdata,
  output logic              err,
  input  logic              err_clr,
  output logic [15:0]       fetch_count
);

  typedef enum logic [1:0] {
    DP_IDLE,
    DP_WAIT,
    DP_DONE
  } dp_state_e;

  // Range limits are evaluated one bit wider than the address so the top of the window cannot wrap.
  localparam logic [W_ADDR:0] BASE_EXT = {1'b0, BASE_ADDR};
  localparam logic [W_ADDR:0] END_EXT  = BASE_EXT + ((W_ADDR+1)'(DEPTH_WORDS) << 2);
  localparam logic [1:0]      WS_CNT   = 2'(WAIT_STATES);

  dp_state_e         dp_state_q, dp_state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              dp_first_q;
  logic              dp_oor_q;
  logic [W_DATA-1:0] hold_q;
  logic              err_q;
  logic [15:0]       count_q;

  logic [W_ADDR:0]   addr_ext;
  logic [W_ADDR-1:0] offset;
  logic              in_range;
  logic              accept;
  logic              data_vld;
  logic              unused_bits;

  assign addr_ext  = {1'b0, mem_addr};
  assign in_range  = (addr_ext >= BASE_EXT) && (addr_ext < END_EXT);
  assign offset    = mem_addr - BASE_ADDR;
  assign sram_addr = offset[AW+1:2];

  // Fetch size and byte offset never change the returned word.
  assign unused_bits = ^{mem_size, offset[1:0], offset[W_ADDR-1:AW+2]};

  // Data is returned in the first data-phase cycle that has no wait states left and no stall.
  assign data_vld     = (dp_state_q == DP_DONE) && !stall_in;
  assign mem_addr_rdy = (dp_state_q == DP_IDLE) || data_vld;
  assign accept       = mem_addr_vld && mem_addr_rdy;
  assign sram_ren     = accept && in_range;

  assign mem_data_vld = data_vld;
  assign err          = err_q;
  assign fetch_count  = count_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    dp_state_d = dp_state_q;
    cnt_d      = cnt_q;
    unique case (dp_state_q)
      DP_WAIT: begin
        if (!stall_in) begin
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd1) dp_state_d = DP_DONE;
        end
      end
      DP_DONE: begin
        if (!stall_in) dp_state_d = DP_IDLE;
      end
      default: begin
        dp_state_d = dp_state_q;
      end
    endcase
    // A new acceptance only happens while idle or on the completing cycle, so it overrides the above.
    if (accept) begin
      cnt_d      = WS_CNT;
      dp_state_d = (WS_CNT == 2'd0) ? DP_DONE : DP_WAIT;
    end
  end

  always_comb begin
    mem_data = '0;
    if (data_vld && !dp_oor_q) mem_data = dp_first_q ? sram_rdata : hold_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_state_q <= DP_IDLE;
      cnt_q      <= 2'd0;
      dp_first_q <= 1'b0;
      dp_oor_q   <= 1'b0;
      hold_q     <= '0;
      err_q      <= 1'b0;
      count_q    <= 16'd0;
    end else begin
      dp_state_q <= dp_state_d;
      cnt_q      <= cnt_d;
      dp_first_q <= accept;
      if (accept) dp_oor_q <= !in_range;
      // SRAM data is only valid in the first data-phase cycle; keep it for any later return cycle.
      if (dp_first_q) hold_q <= sram_rdata;
      if (data_vld && dp_oor_q) err_q <= 1'b1;
      else if (err_clr)         err_q <= 1'b0;
      if (data_vld) count_q <= count_q + 16'd1;
    end
  end

endmodule
